// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory.
// Each access runs IDLE -> ISSUE -> WAIT and returns a one-cycle ack with an optional stall timeout.
module data_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_we,
    input  logic [3:0]  p0_sign_mask,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_we,
    input  logic [3:0]  p1_sign_mask,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall,
    output logic        busy,
    output logic        timeout_err,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        we_q, we_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_mask_q, mem_mask_d;
    logic        memread_q, memread_d;
    logic        memwrite_q, memwrite_d;
    logic        p0_ack_q, p0_ack_d;
    logic        p1_ack_q, p1_ack_d;
    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;
    logic        timeout_q, timeout_d;

    logic        elig0, elig1, winner;
    logic [7:0]  wait_cnt_inc;

    // A port whose ack is showing is finishing; keep it out of this arbitration round.
    assign elig0        = p0_req & ~p0_ack_q;
    assign elig1        = p1_req & ~p1_ack_q;
    assign winner       = (elig0 & elig1) ? ~last_grant_q : elig1;
    assign wait_cnt_inc = wait_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        wait_cnt_d   = wait_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_mask_d   = mem_mask_q;
        memread_d    = 1'b0;
        memwrite_d   = 1'b0;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        timeout_d    = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (elig0 | elig1) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    we_d         = winner ? p1_we : p0_we;
                    mem_addr_d   = winner ? p1_addr : p0_addr;
                    mem_wdata_d  = winner ? p1_wdata : p0_wdata;
                    mem_mask_d   = winner ? p1_sign_mask : p0_sign_mask;
                    // Strobes are registered so they are high exactly during ISSUE.
                    memread_d    = ~we_d;
                    memwrite_d   = we_d;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = 8'd0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (!mem_clk_stall) begin
                    if (!we_q) begin
                        if (grant_q) p1_rdata_d = mem_read_data;
                        else         p0_rdata_d = mem_read_data;
                    end
                    p0_ack_d = ~grant_q;
                    p1_ack_d = grant_q;
                    state_d  = ST_IDLE;
                end else if (wait_cnt_inc == TIMEOUT_C) begin
                    timeout_d = 1'b1;
                    if (grant_q) p1_rdata_d = 32'h0;
                    else         p0_rdata_d = 32'h0;
                    p0_ack_d = ~grant_q;
                    p1_ack_d = grant_q;
                    state_d  = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            wait_cnt_q   <= 8'd0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_mask_q   <= 4'h0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            p0_rdata_q   <= 32'h0;
            p1_rdata_q   <= 32'h0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_mask_q   <= mem_mask_d;
            memread_q    <= memread_d;
            memwrite_q   <= memwrite_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            timeout_q    <= timeout_d;
        end
    end

    assign p0_ack         = p0_ack_q;
    assign p1_ack         = p1_ack_q;
    assign p0_rdata       = p0_rdata_q;
    assign p1_rdata       = p1_rdata_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign mem_sign_mask  = mem_mask_q;
    assign mem_memread    = memread_q;
    assign mem_memwrite   = memwrite_q;
    assign busy           = (state_q != ST_IDLE);
    assign timeout_err    = timeout_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: load, store with stall, round-robin contention,
// stall timeout and reset during WAIT, each step checked against hand-computed values.
module tb_data_mem_arbiter;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_sign_mask, p1_sign_mask;
    logic        p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_memread, mem_memwrite, mem_clk_stall;
    logic        busy, timeout_err;
    logic [1:0]  dbg_state_o;

    int n_cmp = 0;
    int n_err = 0;

    data_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we),
        .p0_sign_mask(p0_sign_mask), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
        .p1_sign_mask(p1_sign_mask), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall),
        .busy(busy), .timeout_err(timeout_err), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs set after this are sampled at the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_sign_mask = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_sign_mask = 0;
        mem_read_data = 32'h0; mem_clk_stall = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_state", 32'(dbg_state_o), 32'(S_IDLE));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", {30'd0, p1_ack, p0_ack}, 32'd0);
        check("rst_strobes", {30'd0, mem_memwrite, mem_memread}, 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);
        check("rst_mask", 32'(mem_sign_mask), 32'd0);
        check("rst_p0_rdata", p0_rdata, 32'h0);
        check("rst_p1_rdata", p1_rdata, 32'h0);
        reset = 1'b0;

        // Single load on port 0, no stall: ack in the third cycle after the request cycle
        p0_req = 1; p0_addr = 32'h0000_0010; p0_we = 0; p0_sign_mask = 4'b0010;
        mem_read_data = 32'hDEAD_BEEF;
        tick();
        check("ld_state_issue", 32'(dbg_state_o), 32'(S_ISSUE));
        check("ld_memread", 32'(mem_memread), 32'd1);
        check("ld_memwrite", 32'(mem_memwrite), 32'd0);
        check("ld_addr", mem_addr, 32'h0000_0010);
        check("ld_mask", 32'(mem_sign_mask), 32'h2);
        check("ld_busy", 32'(busy), 32'd1);
        p0_req = 0;
        tick();
        check("ld_state_wait", 32'(dbg_state_o), 32'(S_WAIT));
        check("ld_memread_off", 32'(mem_memread), 32'd0);
        check("ld_no_early_ack", 32'(p0_ack), 32'd0);
        tick();
        check("ld_ack", 32'(p0_ack), 32'd1);
        check("ld_rdata", p0_rdata, 32'hDEAD_BEEF);
        check("ld_p1_ack", 32'(p1_ack), 32'd0);
        check("ld_idle_busy", 32'(busy), 32'd0);
        tick();
        check("ld_ack_pulse", 32'(p0_ack), 32'd0);
        check("ld_rdata_hold", p0_rdata, 32'hDEAD_BEEF);

        // Store on port 1 with one stall cycle: ack in the fourth cycle
        p1_req = 1; p1_addr = 32'h0000_0020; p1_wdata = 32'h0000_00A5; p1_we = 1;
        p1_sign_mask = 4'b0001;
        mem_read_data = 32'h1234_5678; mem_clk_stall = 1;
        tick();
        check("st_memwrite", 32'(mem_memwrite), 32'd1);
        check("st_memread", 32'(mem_memread), 32'd0);
        check("st_addr", mem_addr, 32'h0000_0020);
        check("st_wdata", mem_write_data, 32'h0000_00A5);
        check("st_mask", 32'(mem_sign_mask), 32'h1);
        p1_req = 0;
        tick();
        check("st_memwrite_off", 32'(mem_memwrite), 32'd0);
        tick();
        check("st_stalled_wait", 32'(dbg_state_o), 32'(S_WAIT));
        check("st_no_early_ack", 32'(p1_ack), 32'd0);
        check("st_addr_stable", mem_addr, 32'h0000_0020);
        check("st_wdata_stable", mem_write_data, 32'h0000_00A5);
        mem_clk_stall = 0;
        tick();
        check("st_ack", 32'(p1_ack), 32'd1);
        check("st_p0_ack", 32'(p0_ack), 32'd0);
        check("st_rdata_unchanged", p1_rdata, 32'h0);
        tick();
        check("st_ack_pulse", 32'(p1_ack), 32'd0);

        // Contention after reset: both requesters held high, grants alternate p0,p1,p0,p1
        reset = 1; tick(); reset = 0;
        p0_req = 1; p0_addr = 32'h0000_0100; p0_we = 0;
        p1_req = 1; p1_addr = 32'h0000_0200; p1_we = 0;
        for (int k = 0; k < 4; k++) begin
            mem_read_data = 32'hC0DE_0000 | 32'(k);
            tick();
            check("rr_memread", 32'(mem_memread), 32'd1);
            check("rr_grant_addr", mem_addr, (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
            check("rr_acks_issue", {30'd0, p1_ack, p0_ack}, (k == 0) ? 32'd0 : ((k % 2 == 0) ? 32'd2 : 32'd1) & 32'd0);
            tick();
            check("rr_acks_wait", {30'd0, p1_ack, p0_ack}, 32'd0);
            tick();
            check("rr_ack", {30'd0, p1_ack, p0_ack}, (k % 2 == 0) ? 32'd1 : 32'd2);
            if (k % 2 == 0) check("rr_p0_rdata", p0_rdata, 32'hC0DE_0000 | 32'(k));
            else            check("rr_p1_rdata", p1_rdata, 32'hC0DE_0000 | 32'(k));
        end
        p0_req = 0; p1_req = 0;
        tick();
        check("rr_done_idle", 32'(busy), 32'd0);

        // Timeout with TIMEOUT_CYCLES=4: stall held, ack after four WAIT cycles with zero data
        p0_req = 1; p0_addr = 32'h0000_0030; p0_we = 0; mem_clk_stall = 1;
        mem_read_data = 32'hFFFF_FFFF;
        tick();
        p0_req = 0;
        tick();
        check("to_wait", 32'(dbg_state_o), 32'(S_WAIT));
        tick(); tick(); tick();
        check("to_no_ack_yet", 32'(p0_ack), 32'd0);
        check("to_no_err_yet", 32'(timeout_err), 32'd0);
        check("to_still_wait", 32'(dbg_state_o), 32'(S_WAIT));
        tick();
        check("to_ack", 32'(p0_ack), 32'd1);
        check("to_rdata_zero", p0_rdata, 32'h0);
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_idle", 32'(dbg_state_o), 32'(S_IDLE));
        mem_clk_stall = 0;
        tick(); tick();
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        check("to_ack_pulse", 32'(p0_ack), 32'd0);

        // Reset during a stalled WAIT: no ack, then a fresh load completes normally
        p1_req = 1; p1_addr = 32'h0000_0044; p1_we = 0; mem_clk_stall = 1;
        tick();
        p1_req = 0;
        tick(); tick();
        check("rw_in_wait", 32'(dbg_state_o), 32'(S_WAIT));
        reset = 1;
        tick();
        check("rw_state", 32'(dbg_state_o), 32'(S_IDLE));
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_err_cleared", 32'(timeout_err), 32'd0);
        check("rw_mem_addr", mem_addr, 32'h0);
        check("rw_acks", {30'd0, p1_ack, p0_ack}, 32'd0);
        reset = 0; mem_clk_stall = 0;
        tick(); tick();
        check("rw_no_late_ack", {30'd0, p1_ack, p0_ack}, 32'd0);
        p0_req = 1; p0_addr = 32'h0000_0040; p0_we = 0; mem_read_data = 32'h55AA_1234;
        tick();
        check("rw_ld_addr", mem_addr, 32'h0000_0040);
        check("rw_ld_memread", 32'(mem_memread), 32'd1);
        p0_req = 0;
        tick(); tick();
        check("rw_ld_ack", 32'(p0_ack), 32'd1);
        check("rw_ld_rdata", p0_rdata, 32'h55AA_1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout_guard observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum WAIT-state cycles before an access is aborted (legal range 1..255).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports pN_req, input, 1 (N=0,1): requester N access request; port 0 is the CPU load/store unit, port 1 the debug/DMA port.
REQ-005 SHALL have ports pN_addr, input, 32: byte address for requester N.
REQ-006 SHALL have ports pN_wdata, input, 32: store data for requester N.
REQ-007 SHALL have ports pN_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have ports pN_sign_mask, input, 4: access size/sign code, passed unmodified to memory.
REQ-009 SHALL have ports pN_ack, output, 1: one-cycle completion pulse to requester N.
REQ-010 SHALL have ports pN_rdata, output, 32: load result for requester N, valid while pN_ack=1.
REQ-011 SHALL have ports mem_addr/mem_write_data (output, 32), mem_sign_mask (output, 4), mem_memread/mem_memwrite (output, 1): registered command to the data memory.
REQ-012 SHALL have ports mem_read_data (input, 32) and mem_clk_stall (input, 1): memory response and busy indication.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port timeout_err, output, 1: sticky abort flag, cleared only by reset.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ISSUE, WAIT.
REQ-016 IDLE: if any eligible request, SHALL latch the winner's addr/wdata/we/sign_mask into mem_* registers, record winner in grant register, go ISSUE; otherwise stay IDLE.
REQ-017 Arbitration SHALL be round-robin: one eligible requester wins alone; both eligible -> the requester not equal to last_grant wins; last_grant updates on each grant.
REQ-018 A requester SHALL be ineligible in any cycle where its own pN_ack is high (prevents re-grant of a request being withdrawn).
REQ-019 ISSUE: SHALL assert exactly one of mem_memread (we=0) or mem_memwrite (we=1) for exactly one cycle, then go WAIT.
REQ-020 mem_addr, mem_write_data, mem_sign_mask SHALL remain stable from ISSUE until return to IDLE.
REQ-021 WAIT: while mem_clk_stall=1, SHALL stay in WAIT and increment an 8-bit wait counter (cleared on entering WAIT).
REQ-022 WAIT with mem_clk_stall=0: SHALL register mem_read_data into the granted pN_rdata (loads only; stores leave pN_rdata unchanged), pulse granted pN_ack the next cycle, go IDLE.
REQ-023 WAIT with counter reaching TIMEOUT_CYCLES and stall still 1: SHALL set timeout_err, pulse granted pN_ack with pN_rdata=32'h0, go IDLE.
REQ-024 Latency from req sampled in IDLE: load, no stall -> ack 3 cycles later; store with one stall cycle -> ack 4 cycles later.
REQ-025 Non-granted requester's ack SHALL stay 0; pending request SHALL be held, not dropped, until served.
REQ-026 Requester deasserting pN_req after grant SHALL NOT cancel the access.
REQ-027 mem_memread and mem_memwrite SHALL never be high simultaneously, nor outside ISSUE.

Reset
REQ-028 On reset=1 at a clock edge, regardless of state (including mid-ISSUE/WAIT), SHALL go IDLE; pN_ack, mem_memread, mem_memwrite, busy, timeout_err, wait counter = 0; mem_addr/mem_write_data/pN_rdata = 32'h0; mem_sign_mask = 4'h0; last_grant = 1 (port 0 wins first tie).
REQ-029 An access interrupted by reset SHALL produce no ack.

Verification
REQ-030 Single load: p0_req=1, p0_addr=32'h0000_0010, we=0; memory returns 32'hDEADBEEF, no stall -> mem_memread high 1 cycle, p0_ack pulse 3 cycles after req, p0_rdata=32'hDEADBEEF.
REQ-031 Store: p1_req=1, addr=32'h0000_0020, wdata=32'h0000_00A5, sign_mask=4'b0001, stall 1 cycle -> mem_memwrite 1 cycle with those values, p1_ack 4 cycles after req, p1_rdata unchanged.
REQ-032 Contention: p0_req and p1_req asserted together after reset, held until ack -> grants alternate p0,p1,p0,p1 over four accesses; never two acks in one cycle.
REQ-033 Timeout: TIMEOUT_CYCLES=4, mem_clk_stall held 1 -> p0_ack after 4 WAIT cycles, p0_rdata=0, timeout_err=1 and remains 1 until reset.
REQ-034 Reset in WAIT: assert reset during stall -> next cycle IDLE, busy=0, no ack; subsequent load completes normally.
